// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage with req/ack data-memory sequencing and registered writeback.
// Optional access timeout with sticky mem_err is enabled by defining MEM_TIMEOUT_EN.
module mem_wb_stage #(
  parameter int DSIZE   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             memEnab,
  input  logic             memWriteEnab,
  input  logic [DSIZE-1:0] storeData,
  input  logic             sel_mem2Reg,
  input  logic             RFwriteEnab,
  input  logic [DSIZE-1:0] ALUresult,
  input  logic [2:0]       RFdest_rd,
  input  logic [3:0]       ALUstatus,
  output logic             mem_req,
  output logic             mem_we,
  output logic [DSIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic             stall,
  output logic             RFwriteEnab_wb,
  output logic [2:0]       RFdest_wb,
  output logic [DSIZE-1:0] RFdata_wb,
  output logic [3:0]       status_o,
  output logic             mem_err
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [DSIZE-1:0] addr_q, addr_d, wdata_q, wdata_d, wbdata_q, wbdata_d;
  logic             we_q, we_d, rfwe_q, rfwe_d, sel_q, sel_d, wbwe_q, wbwe_d;
  logic [2:0]       dest_q, dest_d, wbdest_q, wbdest_d;
  logic [3:0]       status_q, status_d;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    dest_d   = dest_q;
    rfwe_d   = rfwe_q;
    sel_d    = sel_q;
    wbwe_d   = 1'b0;
    wbdest_d = wbdest_q;
    wbdata_d = wbdata_q;
    status_d = status_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    if (state_q == IDLE) begin
      if (memEnab) begin
        state_d = ACCESS;
        addr_d  = ALUresult;
        we_d    = memWriteEnab;
        wdata_d = storeData;
        dest_d  = RFdest_rd;
        rfwe_d  = RFwriteEnab;
        sel_d   = sel_mem2Reg;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end else begin
        wbwe_d   = RFwriteEnab;
        wbdest_d = RFdest_rd;
        wbdata_d = ALUresult;
        status_d = ALUstatus;
      end
    end else if (mem_ack) begin
      state_d = IDLE;
      if (!we_q) begin
        wbwe_d   = rfwe_q;
        wbdest_d = dest_q;
        wbdata_d = sel_q ? mem_rdata : addr_q;
      end
    end
`ifdef MEM_TIMEOUT_EN
    // ack in the final allowed cycle takes the branch above and completes normally
    else if (cnt_q == CW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      dest_q   <= '0;
      rfwe_q   <= 1'b0;
      sel_q    <= 1'b0;
      wbwe_q   <= 1'b0;
      wbdest_q <= '0;
      wbdata_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      dest_q   <= dest_d;
      rfwe_q   <= rfwe_d;
      sel_q    <= sel_d;
      wbwe_q   <= wbwe_d;
      wbdest_q <= wbdest_d;
      wbdata_q <= wbdata_d;
      status_q <= status_d;
    end
  end
`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif
  assign mem_req        = (state_q == ACCESS);
  assign mem_we         = mem_req & we_q;
  assign mem_addr       = mem_req ? addr_q : '0;
  assign mem_wdata      = mem_req ? wdata_q : '0;
  // reset forces stall low at once even if EX is still presenting a memory op
  assign stall          = Rst & (mem_req ? ~mem_ack : memEnab);
  assign RFwriteEnab_wb = wbwe_q;
  assign RFdest_wb      = wbdest_q;
  assign RFdata_wb      = wbdata_q;
  assign status_o       = status_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed-vector bench for mem_wb_stage.
module tb_mem_wb_stage;
  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        memEnab, memWriteEnab, sel_mem2Reg, RFwriteEnab, mem_ack;
  logic [15:0] storeData, ALUresult, mem_rdata;
  logic [2:0]  RFdest_rd;
  logic [3:0]  ALUstatus;
  logic        mem_req, mem_we, stall, RFwriteEnab_wb, mem_err;
  logic [15:0] mem_addr, mem_wdata, RFdata_wb;
  logic [2:0]  RFdest_wb;
  logic [3:0]  status_o;
  int n_vec = 0;
  int n_err = 0;

  mem_wb_stage #(.DSIZE(16), .TIMEOUT(15)) dut (
    .Clk(Clk), .Rst(Rst), .memEnab(memEnab), .memWriteEnab(memWriteEnab),
    .storeData(storeData), .sel_mem2Reg(sel_mem2Reg), .RFwriteEnab(RFwriteEnab),
    .ALUresult(ALUresult), .RFdest_rd(RFdest_rd), .ALUstatus(ALUstatus),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .RFwriteEnab_wb(RFwriteEnab_wb), .RFdest_wb(RFdest_wb), .RFdata_wb(RFdata_wb),
    .status_o(status_o), .mem_err(mem_err)
  );

  always #5 Clk = ~Clk;

  task cyc;
    @(posedge Clk);
    #1;
  endtask

  task idle_in;
    memEnab = 0; memWriteEnab = 0; sel_mem2Reg = 0; RFwriteEnab = 0;
    storeData = 0; ALUresult = 0; RFdest_rd = 0; ALUstatus = 0;
  endtask

  task test_reset;
    idle_in(); mem_ack = 0; mem_rdata = 0;
    #3;
    n_vec++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, stall, RFwriteEnab_wb, RFdest_wb, RFdata_wb, status_o, mem_err} !== 61'd0) begin
      n_err++; $display("FAIL reset_outputs got req=%b we=%b addr=%h wd=%h stall=%b wbwe=%b dest=%0d data=%h st=%b err=%b required all 0",
        mem_req, mem_we, mem_addr, mem_wdata, stall, RFwriteEnab_wb, RFdest_wb, RFdata_wb, status_o, mem_err);
    end
    cyc(); Rst = 1; cyc();
  endtask

  task test_nonmem;
    ALUresult = 16'h1234; RFdest_rd = 5; RFwriteEnab = 1; ALUstatus = 4'b1010;
    #1;
    n_vec++;
    if ({stall, mem_req} !== 2'b00) begin
      n_err++; $display("FAIL nonmem_stall got stall=%b req=%b required 0 0", stall, mem_req);
    end
    cyc();
    n_vec++;
    if ({RFwriteEnab_wb, RFdest_wb, RFdata_wb, status_o} !== {1'b1, 3'd5, 16'h1234, 4'b1010}) begin
      n_err++; $display("FAIL nonmem_wb got we=%b dest=%0d data=%h st=%b required 1 5 1234 1010",
        RFwriteEnab_wb, RFdest_wb, RFdata_wb, status_o);
    end
    idle_in();
  endtask

  task test_load_wait;
    memEnab = 1; memWriteEnab = 0; ALUresult = 16'h0040; RFdest_rd = 3; RFwriteEnab = 1;
    sel_mem2Reg = 1; ALUstatus = 4'b1111;
    #1;
    n_vec++;
    if ({stall, mem_req} !== 2'b10) begin
      n_err++; $display("FAIL load_entry got stall=%b req=%b required 1 0", stall, mem_req);
    end
    cyc();
    memEnab = 1; ALUresult = 16'hFFFF; RFdest_rd = 7; memWriteEnab = 1; storeData = 16'h5555;
    for (int i = 1; i <= 3; i++) begin
      n_vec++;
      if ({mem_req, mem_we, mem_addr, stall, RFwriteEnab_wb} !== {1'b1, 1'b0, 16'h0040, 1'b1, 1'b0}) begin
        n_err++; $display("FAIL load_wait%0d got req=%b we=%b addr=%h stall=%b wbwe=%b required 1 0 0040 1 0",
          i, mem_req, mem_we, mem_addr, stall, RFwriteEnab_wb);
      end
      cyc();
    end
    idle_in(); mem_ack = 1; mem_rdata = 16'hBEEF;
    #1;
    n_vec++;
    if ({mem_req, mem_we, mem_addr, stall} !== {1'b1, 1'b0, 16'h0040, 1'b0}) begin
      n_err++; $display("FAIL load_ack got req=%b we=%b addr=%h stall=%b required 1 0 0040 0",
        mem_req, mem_we, mem_addr, stall);
    end
    cyc(); mem_ack = 0; mem_rdata = 0;
    n_vec++;
    if ({RFwriteEnab_wb, RFdest_wb, RFdata_wb, status_o, mem_req} !== {1'b1, 3'd3, 16'hBEEF, 4'b1010, 1'b0}) begin
      n_err++; $display("FAIL load_wb got we=%b dest=%0d data=%h st=%b req=%b required 1 3 beef 1010 0",
        RFwriteEnab_wb, RFdest_wb, RFdata_wb, status_o, mem_req);
    end
  endtask

  task test_store;
    ALUresult = 16'h0001; RFdest_rd = 2; RFwriteEnab = 1; ALUstatus = 4'b0110;
    cyc();
    memEnab = 1; memWriteEnab = 1; ALUresult = 16'h0010; storeData = 16'h00AA;
    RFdest_rd = 6; RFwriteEnab = 1; ALUstatus = 4'b0101;
    cyc();
    idle_in(); mem_ack = 1;
    #1;
    n_vec++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, stall} !== {1'b1, 1'b1, 16'h0010, 16'h00AA, 1'b0}) begin
      n_err++; $display("FAIL store_ack got req=%b we=%b addr=%h wd=%h stall=%b required 1 1 0010 00aa 0",
        mem_req, mem_we, mem_addr, mem_wdata, stall);
    end
    cyc(); mem_ack = 0;
    n_vec++;
    if ({mem_req, mem_we, mem_wdata, RFwriteEnab_wb, status_o} !== {1'b0, 1'b0, 16'h0000, 1'b0, 4'b0110}) begin
      n_err++; $display("FAIL store_done got req=%b we=%b wd=%h wbwe=%b st=%b required 0 0 0000 0 0110",
        mem_req, mem_we, mem_wdata, RFwriteEnab_wb, status_o);
    end
  endtask

  task test_back_to_back;
    memEnab = 1; memWriteEnab = 0; ALUresult = 16'h0100; RFdest_rd = 1; RFwriteEnab = 1; sel_mem2Reg = 1;
    cyc();
    ALUresult = 16'h0200; RFdest_rd = 2; mem_ack = 1; mem_rdata = 16'h1111;
    cyc(); mem_ack = 0;
    n_vec++;
    if ({RFwriteEnab_wb, RFdest_wb, RFdata_wb, stall, mem_req} !== {1'b1, 3'd1, 16'h1111, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL b2b_first got we=%b dest=%0d data=%h stall=%b req=%b required 1 1 1111 1 0",
        RFwriteEnab_wb, RFdest_wb, RFdata_wb, stall, mem_req);
    end
    cyc();
    idle_in(); mem_ack = 1; mem_rdata = 16'h2222;
    #1;
    n_vec++;
    if ({mem_req, mem_addr, RFwriteEnab_wb} !== {1'b1, 16'h0200, 1'b0}) begin
      n_err++; $display("FAIL b2b_second_access got req=%b addr=%h wbwe=%b required 1 0200 0",
        mem_req, mem_addr, RFwriteEnab_wb);
    end
    cyc(); mem_ack = 0;
    n_vec++;
    if ({RFwriteEnab_wb, RFdest_wb, RFdata_wb} !== {1'b1, 3'd2, 16'h2222}) begin
      n_err++; $display("FAIL b2b_second_wb got we=%b dest=%0d data=%h required 1 2 2222",
        RFwriteEnab_wb, RFdest_wb, RFdata_wb);
    end
  endtask

  task test_ack_idle;
    ALUresult = 16'h55AA; RFdest_rd = 7; RFwriteEnab = 1; sel_mem2Reg = 1; ALUstatus = 4'b1001;
    mem_ack = 1; mem_rdata = 16'hDEAD;
    cyc(); mem_ack = 0;
    n_vec++;
    if ({RFwriteEnab_wb, RFdest_wb, RFdata_wb, status_o, mem_req} !== {1'b1, 3'd7, 16'h55AA, 4'b1001, 1'b0}) begin
      n_err++; $display("FAIL ack_idle got we=%b dest=%0d data=%h st=%b req=%b required 1 7 55aa 1001 0",
        RFwriteEnab_wb, RFdest_wb, RFdata_wb, status_o, mem_req);
    end
    idle_in();
  endtask

  task test_reset_mid;
    memEnab = 1; ALUresult = 16'h0080; RFdest_rd = 4; RFwriteEnab = 1; sel_mem2Reg = 1;
    cyc(); idle_in(); cyc(); cyc();
    #2; Rst = 0; #1;
    n_vec++;
    if ({mem_req, stall, mem_addr, RFwriteEnab_wb, RFdest_wb, RFdata_wb, status_o, mem_err} !== 43'd0) begin
      n_err++; $display("FAIL reset_mid got req=%b stall=%b addr=%h wbwe=%b dest=%0d data=%h st=%b err=%b required all 0",
        mem_req, stall, mem_addr, RFwriteEnab_wb, RFdest_wb, RFdata_wb, status_o, mem_err);
    end
    cyc(); Rst = 1;
    ALUresult = 16'h0ABC; RFdest_rd = 6; RFwriteEnab = 1; ALUstatus = 4'b0011;
    #1;
    n_vec++;
    if ({mem_req, stall} !== 2'b00) begin
      n_err++; $display("FAIL reset_mid_idle got req=%b stall=%b required 0 0", mem_req, stall);
    end
    cyc();
    n_vec++;
    if ({RFwriteEnab_wb, RFdest_wb, RFdata_wb, status_o} !== {1'b1, 3'd6, 16'h0ABC, 4'b0011}) begin
      n_err++; $display("FAIL reset_mid_nonmem got we=%b dest=%0d data=%h st=%b required 1 6 0abc 0011",
        RFwriteEnab_wb, RFdest_wb, RFdata_wb, status_o);
    end
    idle_in();
  endtask

`ifdef MEM_TIMEOUT_EN
  task test_timeout;
    memEnab = 1; ALUresult = 16'h0300; RFdest_rd = 4; RFwriteEnab = 1; sel_mem2Reg = 1;
    cyc(); idle_in();
    for (int i = 1; i <= 15; i++) begin
      n_vec++;
      if ({mem_req, mem_err} !== 2'b10) begin
        n_err++; $display("FAIL timeout_wait%0d got req=%b err=%b required 1 0", i, mem_req, mem_err);
      end
      cyc();
    end
    n_vec++;
    if ({mem_req, RFwriteEnab_wb, mem_err} !== 3'b001) begin
      n_err++; $display("FAIL timeout_abort got req=%b wbwe=%b err=%b required 0 0 1", mem_req, RFwriteEnab_wb, mem_err);
    end
    cyc(); cyc();
    n_vec++;
    if (mem_err !== 1'b1) begin
      n_err++; $display("FAIL timeout_sticky got err=%b required 1", mem_err);
    end
    Rst = 0; #2; Rst = 1;
    memEnab = 1; ALUresult = 16'h0300; RFdest_rd = 4; RFwriteEnab = 1; sel_mem2Reg = 1;
    cyc(); idle_in();
    for (int i = 1; i <= 14; i++) cyc();
    mem_ack = 1; mem_rdata = 16'h7777;
    cyc(); mem_ack = 0;
    n_vec++;
    if ({RFwriteEnab_wb, RFdest_wb, RFdata_wb, mem_err, mem_req} !== {1'b1, 3'd4, 16'h7777, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL timeout_ack_wins got we=%b dest=%0d data=%h err=%b req=%b required 1 4 7777 0 0",
        RFwriteEnab_wb, RFdest_wb, RFdata_wb, mem_err, mem_req);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nonmem();
    test_load_wait();
    test_store();
    test_back_to_back();
    test_ack_idle();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access stage that consumes the EX:Mem pipeline register outputs and produces the registered writeback to the register file.
- Sequences data-memory loads and stores over a req/ack handshake with variable wait states.
- Stalls the upstream pipeline while an access is outstanding.
- Selects ALU result or load data for writeback and holds the architectural status flags.

Parameters:
DSIZE, 16, data and address width
TIMEOUT, 15, max wait cycles for mem_ack before abort (used only with MEM_TIMEOUT_EN)

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  asynchronous, active-low reset
memEnab  input  1  memory instruction present this cycle (unregistered from EX)
memWriteEnab  input  1  1=store, 0=load; valid with memEnab
storeData  input  DSIZE  store data, valid with memEnab
sel_mem2Reg  input  1  1=writeback load data, 0=writeback ALUresult
RFwriteEnab  input  1  instruction writes RF
ALUresult  input  DSIZE  ALU result / memory address
RFdest_rd  input  3  RF write destination
ALUstatus  input  4  ALU flags of this instruction
mem_req  output  1  memory request
mem_we  output  1  memory write strobe, qualified by mem_req
mem_addr  output  DSIZE  memory address
mem_wdata  output  DSIZE  memory write data
mem_ack  input  1  memory completion; rdata valid same cycle for loads
mem_rdata  input  DSIZE  load data
stall  output  1  freeze upstream stages
RFwriteEnab_wb  output  1  registered RF write enable
RFdest_wb  output  3  registered RF destination
RFdata_wb  output  DSIZE  registered RF write data
status_o  output  4  architectural status flags
mem_err  output  1  sticky access-timeout error

Behaviour:
- Reset (Rst=0, async): every output and internal register 0; FSM to IDLE. Takes effect immediately, including mid-access; mem_req drops without waiting for ack.
- FSM states: IDLE, ACCESS.
- IDLE, memEnab=0:
  - Non-memory instruction accepted each cycle; 1-cycle latency.
  - Next edge: RFwriteEnab_wb<=RFwriteEnab, RFdest_wb<=RFdest_rd, RFdata_wb<=ALUresult, status_o<=ALUstatus.
- IDLE, memEnab=1:
  - stall=1 combinationally this cycle.
  - Next edge: capture addr=ALUresult, we=memWriteEnab, wdata=storeData, dest, RFwriteEnab, sel_mem2Reg; go to ACCESS.
  - RFwriteEnab_wb<=0 (bubble); status_o unchanged.
- ACCESS:
  - mem_req=1; mem_we/mem_addr/mem_wdata from captured registers, stable until ack.
  - stall = ~mem_ack.
  - On mem_ack=1, next edge returns to IDLE and:
    - load: RFwriteEnab_wb<=captured RFwriteEnab, RFdest_wb<=dest, RFdata_wb<=mem_rdata;
    - store: RFwriteEnab_wb<=0.
  - Without ack: RFwriteEnab_wb<=0 each cycle.
  - Upstream inputs are ignored in ACCESS.
- Load latency: writeback visible 1 cycle after the ack cycle. Minimum memory instruction occupancy is 2 cycles (entry + ack cycle).
- Back-to-back: a memory instruction presented in the cycle after ack is accepted normally from IDLE.
- mem_ack while IDLE: ignored.
- sel_mem2Reg=1 with memEnab=0: treated as non-memory; RFdata_wb<=ALUresult.
- status_o updates only on accepted non-memory instructions.
- Outputs mem_req, mem_we, mem_addr, mem_wdata are 0 in IDLE.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - Counter clears on ACCESS entry and increments each ACCESS cycle without ack.
  - When the count reaches TIMEOUT with no ack, next edge goes to IDLE with RFwriteEnab_wb<=0 (access dropped) and sets mem_err=1.
  - mem_err is sticky until reset.
  - An ack arriving in the same cycle the count reaches TIMEOUT wins (normal completion, no error).
- Undefined:
  - No counter; ACCESS waits indefinitely.
  - mem_err tied 0.

Test Plan:
- Reset mid-load: memEnab=1 load, ack withheld 3 cycles, drive Rst=0 asynchronously -> mem_req, stall, all outputs 0 immediately; after release, IDLE, non-memory op accepted.
- Non-memory stream: ALUresult=16'h1234, RFdest_rd=5, RFwriteEnab=1, ALUstatus=4'b1010 -> next cycle RFwriteEnab_wb=1, RFdest_wb=5, RFdata_wb=16'h1234, status_o=4'b1010, stall=0.
- Load, 3 wait states: ALUresult=16'h0040, dest=3, ack on 4th ACCESS cycle with mem_rdata=16'hBEEF -> mem_addr=16'h0040 and mem_we=0 throughout; stall high for entry cycle plus 3 ACCESS cycles, low in ack cycle; next cycle RFwriteEnab_wb=1, RFdest_wb=3, RFdata_wb=16'hBEEF.
- Store, zero wait: memWriteEnab=1, ALUresult=16'h0010, storeData=16'h00AA, ack in first ACCESS cycle -> mem_we=1, mem_wdata=16'h00AA for exactly 1 cycle; RFwriteEnab_wb stays 0; status_o unchanged.
- Back-to-back loads: second memEnab presented the cycle after first ack -> second access starts without an idle gap; both writebacks occur with correct data and order.
- MEM_TIMEOUT_EN, TIMEOUT=15: no ack -> mem_req drops after 15 ACCESS cycles, mem_err=1 and stays 1; no RF write. Repeat with ack on cycle 15 -> normal completion, mem_err=0.
